// File: rtl/req_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : req_arb_pkg
// Description : Shared definitions for the request FIFO arbiter: message
//               delimiter byte, arbiter state encoding and a constant-safe
//               ceil(log2) helper used to size indices and counters.
// Revision    : 1.0 - initial release
// ============================================================================
package req_arb_pkg;

   // Low byte of a word that terminates a message
   localparam logic [7:0] DELIM = 8'hee;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_t;

   // ceil(log2(value)); returns 0 for value <= 1
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Scans the request vector
//               starting at the pointer and wrapping modulo NREQ; reports
//               the first asserted index.
// Ports       : req   [NREQ]  - request vector
//               rr    [IDX_W] - index to start scanning from
//               valid         - at least one request asserted
//               idx   [IDX_W] - selected index (rr when nothing requests)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
   import req_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int IDX_W = clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] rr,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest hit wins.
   // NREQ is a power of two, so the IDX_W-bit add wraps modulo NREQ.
   always_comb begin
      valid = 1'b0;
      idx   = rr;
      cand  = rr;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = rr + IDX_W'(k);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/req_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : req_fifo_arbiter
// Description : Round-robin arbiter draining NREQ request FIFOs into a single
//               registered output stream. A grant is held for a whole message
//               (ended by a DELIM low byte) unless MAX_BURST words have been
//               read or the granted FIFO stays empty for STALL_MAX cycles.
// Ports       : clk, reset         - clock, async active-high reset
//               fifo_empty [NREQ]  - per-FIFO empty flags
//               fifo_rdata [NREQ*WIDTH] - per-FIFO head words
//               fifo_rd    [NREQ]  - per-FIFO read strobe (combinational)
//               out_valid/out_ready - output handshake
//               out_data, out_src, out_last - registered output word
// Revision    : 1.0 - initial release
// ============================================================================
module req_fifo_arbiter
   import req_arb_pkg::*;
#(
   parameter  int WIDTH     = 64,
   parameter  int NREQ      = 4,
   parameter  int MAX_BURST = 8,
   parameter  int STALL_MAX = 16,
   localparam int IDX_W     = clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       fifo_empty,
   input  logic [NREQ*WIDTH-1:0] fifo_rdata,
   output logic [NREQ-1:0]       fifo_rd,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic [IDX_W-1:0]      out_src,
   output logic                  out_last,
   input  logic                  out_ready
);

   localparam int BC_W = clog2(MAX_BURST + 1);
   localparam int SC_W = clog2(STALL_MAX + 1);
   localparam logic [BC_W-1:0] BURST_LIM = BC_W'(MAX_BURST);
   localparam logic [SC_W-1:0] STALL_LIM = SC_W'(STALL_MAX);

   arb_state_t        state;
   logic [IDX_W-1:0]  grant;
   logic [IDX_W-1:0]  rr;
   logic [BC_W-1:0]   word_cnt;
   logic [SC_W-1:0]   stall_cnt;

   logic [WIDTH-1:0]  head [NREQ];
   logic [WIDTH-1:0]  grant_data;
   logic              grant_empty;
   logic              out_free;
   logic              rd_en;
   logic              is_delim;
   logic [BC_W-1:0]   word_nxt;
   logic [SC_W-1:0]   stall_nxt;
   logic              rel_grant;
   logic              pick_valid;
   logic [IDX_W-1:0]  pick_idx;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         head[i] = fifo_rdata[i*WIDTH +: WIDTH];
      end
   end

   rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req   (~fifo_empty),
      .rr    (rr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign grant_data  = head[grant];
   assign grant_empty = fifo_empty[grant];
   // The output register can take a word when empty or being drained this cycle
   assign out_free    = ~out_valid | out_ready;
   assign rd_en       = (state == XFER) & ~grant_empty & out_free;
   assign is_delim    = (grant_data[7:0] == DELIM);
   assign word_nxt    = word_cnt + BC_W'(1);
   assign stall_nxt   = stall_cnt + SC_W'(1);

   // Delimiter and burst limit on the same word collapse into one release
   assign rel_grant = (rd_en & (is_delim | (word_nxt == BURST_LIM)))
                    | ((state == XFER) & grant_empty & (stall_nxt == STALL_LIM));

   always_comb begin
      fifo_rd        = '0;
      fifo_rd[grant] = rd_en;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         grant     <= '0;
         rr        <= '0;
         word_cnt  <= '0;
         stall_cnt <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         out_last  <= 1'b0;
      end else begin
         // Output register: load on read, otherwise drop once accepted
         if (rd_en) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_src   <= grant;
            out_last  <= is_delim;
         end else if (out_valid & out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant     <= pick_idx;
                  word_cnt  <= '0;
                  stall_cnt <= '0;
                  state     <= XFER;
               end
            end
            XFER: begin
               if (rd_en) begin
                  word_cnt  <= word_nxt;
                  stall_cnt <= '0;
               end else if (grant_empty) begin
                  stall_cnt <= stall_nxt;
               end
               if (rel_grant) begin
                  state <= IDLE;
                  rr    <= grant + IDX_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_req_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_req_fifo_arbiter
// Description : Self-checking bench for req_fifo_arbiter. Behavioural FIFOs
//               feed the DUT; expected output words are queued as stimulus is
//               loaded and compared as the DUT hands words downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_req_fifo_arbiter;

   localparam int WIDTH = 64;
   localparam int NREQ  = 4;

   typedef struct packed {
      logic [1:0]  src;
      logic        last;
      logic [63:0] data;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       fifo_empty;
   logic [NREQ*WIDTH-1:0] fifo_rdata;
   logic [NREQ-1:0]       fifo_rd;
   logic                  out_valid;
   logic [WIDTH-1:0]      out_data;
   logic [1:0]            out_src;
   logic                  out_last;
   logic                  out_ready;

   logic [63:0] q0[$], q1[$], q2[$], q3[$];
   exp_t        exp_q[$];
   int          acc_cyc[$];
   int          cyc = 0;
   int          acc_n = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [3:0]  last_rd = '0;

   always #5 clk = ~clk;

   req_fifo_arbiter #(
      .WIDTH     (WIDTH),
      .NREQ      (NREQ),
      .MAX_BURST (8),
      .STALL_MAX (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_rd    (fifo_rd),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_src    (out_src),
      .out_last   (out_last),
      .out_ready  (out_ready)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mk(input int f, input int i, input bit delim);
      return {16'hC0DE, 8'(f), 32'(i), (delim ? 8'hee : 8'h11)};
   endfunction

   task automatic refresh();
      fifo_empty = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
      fifo_rdata = '0;
      if (q0.size() > 0) fifo_rdata[0*64 +: 64] = q0[0];
      if (q1.size() > 0) fifo_rdata[1*64 +: 64] = q1[0];
      if (q2.size() > 0) fifo_rdata[2*64 +: 64] = q2[0];
      if (q3.size() > 0) fifo_rdata[3*64 +: 64] = q3[0];
   endtask

   task automatic push_fifo(input int f, input logic [63:0] d);
      case (f)
         0: q0.push_back(d);
         1: q1.push_back(d);
         2: q2.push_back(d);
         default: q3.push_back(d);
      endcase
      refresh();
   endtask

   task automatic expect_word(input int f, input logic [63:0] d);
      exp_t e;
      e.src  = 2'(f);
      e.last = (d[7:0] == 8'hee);
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic send(input int f, input logic [63:0] d);
      push_fifo(f, d);
      expect_word(f, d);
   endtask

   // One clock: sample at negedge, then pop model FIFOs just after posedge
   task automatic tick();
      logic [3:0] snap;
      exp_t       e;
      @(negedge clk);
      snap    = fifo_rd;
      last_rd = snap;
      check("rd_legal", (($countones(snap) <= 1) && ((snap & fifo_empty) == 4'b0)), 1'b1);
      if (!reset && out_valid) begin
         if (!out_ready) begin
            check("hold_rd", fifo_rd, 4'b0);
            if (exp_q.size() > 0) check("hold_data", out_data, exp_q[0].data);
         end else begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", out_data, 64'h0);
            end else begin
               e = exp_q.pop_front();
               check("out_data", out_data, e.data);
               check("out_src", out_src, e.src);
               check("out_last", out_last, e.last);
            end
            acc_cyc.push_back(cyc);
            acc_n++;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      if (snap[0] && q0.size() > 0) void'(q0.pop_front());
      if (snap[1] && q1.size() > 0) void'(q1.pop_front());
      if (snap[2] && q2.size() > 0) void'(q2.pop_front());
      if (snap[3] && q3.size() > 0) void'(q3.pop_front());
      refresh();
   endtask

   task automatic run_until_idle(input int budget, input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) check({tag, "_timeout"}, 1'b0, 1'b1);
   endtask

   task automatic wait_accepts(input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (!(acc_n >= target && out_valid) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) check({tag, "_timeout"}, 1'b0, 1'b1);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
      exp_q.delete();
      acc_cyc.delete();
      refresh();
      tick();
      check("rst_valid", out_valid, 1'b0);
      check("rst_data", out_data, 64'h0);
      check("rst_src", out_src, 2'd0);
      check("rst_last", out_last, 1'b0);
      check("rst_rd", fifo_rd, 4'b0);
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got no end, expected end");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int base;
      reset     = 1'b1;
      out_ready = 1'b1;
      refresh();

      // Single message from FIFO 0, back-to-back output, latency from IDLE
      apply_reset();
      c0 = cyc;
      send(0, mk(0, 0, 0));
      send(0, mk(0, 1, 0));
      send(0, mk(0, 2, 1));
      run_until_idle(50, "t1");
      check("t1_count", acc_cyc.size(), 3);
      if (acc_cyc.size() == 3) begin
         check("t1_latency", acc_cyc[0] - c0, 2);
         check("t1_gap01", acc_cyc[1] - acc_cyc[0], 1);
         check("t1_gap12", acc_cyc[2] - acc_cyc[1], 1);
      end

      // One delimiter word per FIFO: round-robin order with an IDLE gap
      apply_reset();
      for (int f = 0; f < 4; f++) send(f, mk(f, 0, 1));
      run_until_idle(50, "t2");
      check("t2_count", acc_cyc.size(), 4);
      if (acc_cyc.size() == 4) begin
         for (int i = 1; i < 4; i++) begin
            check($sformatf("t2_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 2);
         end
      end

      // Burst limit: 8 from FIFO 1, then FIFO 2, then the rest of FIFO 1
      apply_reset();
      for (int i = 0; i < 12; i++) push_fifo(1, mk(1, i, 0));
      push_fifo(2, mk(2, 0, 0));
      for (int i = 0; i < 8; i++) expect_word(1, mk(1, i, 0));
      expect_word(2, mk(2, 0, 0));
      for (int i = 8; i < 12; i++) expect_word(1, mk(1, i, 0));
      run_until_idle(200, "t3");
      check("t3_count", acc_cyc.size(), 13);

      // Backpressure for 5 cycles mid-message; last word is delimiter and
      // burst limit at once, then rr must point at FIFO 1
      apply_reset();
      for (int i = 0; i < 8; i++) send(0, mk(0, i, i == 7));
      wait_accepts(2, 50, "t4_wait");
      out_ready = 1'b0;
      repeat (5) tick();
      out_ready = 1'b1;
      run_until_idle(50, "t4");
      check("t4_count", acc_cyc.size(), 8);
      send(1, mk(1, 0, 1));
      send(0, mk(0, 9, 1));
      run_until_idle(50, "t4_rr");
      check("t4_rr_count", acc_cyc.size(), 10);

      // Stall release: FIFO 3 runs dry, FIFO 0 gets the next grant
      apply_reset();
      push_fifo(3, mk(3, 0, 0));
      push_fifo(3, mk(3, 1, 0));
      expect_word(3, mk(3, 0, 0));
      expect_word(3, mk(3, 1, 0));
      wait_accepts(1, 50, "t5_wait");
      push_fifo(0, mk(0, 0, 1));
      expect_word(0, mk(0, 0, 1));
      run_until_idle(100, "t5");
      check("t5_count", acc_cyc.size(), 3);
      if (acc_cyc.size() == 3) check("t5_stall_gap", acc_cyc[2] - acc_cyc[1], 18);

      // Reset mid-message: output dropped at once, arbitration from FIFO 0
      apply_reset();
      send(1, mk(1, 0, 1));
      run_until_idle(50, "t6a");
      tick();
      for (int i = 0; i < 4; i++) send(2, mk(2, i, i == 3));
      base = acc_n;
      wait_accepts(base + 1, 50, "t6_wait");
      check("t6_valid_before", out_valid, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("t6_valid_async", out_valid, 1'b0);
      check("t6_rd_async", fifo_rd, 4'b0);
      exp_q.delete();
      push_fifo(0, mk(0, 9, 1));
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("t6_rd_after_rst", last_rd, 4'b0);
      expect_word(0, mk(0, 9, 1));
      foreach (q2[i]) expect_word(2, q2[i]);
      run_until_idle(100, "t6");
      check("t6_drained", q0.size() + q2.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/req_fifo_arbiter.md
REQ_FIFO_ARBITER -- requirements
Module: req_fifo_arbiter

Interface
REQ-001 Parameter WIDTH, default 64, data word width of each request FIFO.
REQ-002 Parameter NREQ, default 4, number of request FIFOs arbitrated (power of two, 2..8).
REQ-003 Parameter MAX_BURST, default 8, maximum words per grant before forced release.
REQ-004 Parameter STALL_MAX, default 16, consecutive empty cycles tolerated mid-message before forced release.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 fifo_empty  input  NREQ  per-FIFO empty flag.
REQ-008 fifo_rdata  input  NREQ*WIDTH  per-FIFO head word, FIFO i at bits [i*WIDTH +: WIDTH], valid whenever not empty.
REQ-009 fifo_rd  output  NREQ  per-FIFO read strobe, one-hot or zero, combinational.
REQ-010 out_valid  output  1  output word valid.
REQ-011 out_data  output  WIDTH  registered output word.
REQ-012 out_src  output  log2(NREQ)  index of FIFO that supplied out_data.
REQ-013 out_last  output  1  out_data ends a message (low byte == DELIM 8'hee).
REQ-014 out_ready  input  1  downstream accepts out_data when out_valid & out_ready.

Function
REQ-015 FSM states: IDLE, XFER; one grant index g and round-robin pointer rr held in registers.
REQ-016 IDLE: if any fifo_empty[i]==0, pick first non-empty index scanning rr, rr+1, ... mod NREQ; register g, clear word and stall counters, go XFER next cycle; fifo_rd all zero in IDLE.
REQ-017 XFER: fifo_rd[g] = ~fifo_empty[g] & (~out_valid | out_ready); all other bits zero.
REQ-018 On fifo_rd[g]: out_data <= fifo_rdata[g], out_src <= g, out_last <= (fifo_rdata[g][7:0]==8'hee), out_valid <= 1 next edge.
REQ-019 out_valid clears on accept (out_valid & out_ready) with no new load that cycle; out_data/out_src/out_last hold while out_valid & ~out_ready.
REQ-020 Word counter increments per fifo_rd; release when loaded word is delimiter or counter reaches MAX_BURST (that read inclusive).
REQ-021 Stall counter increments each XFER cycle with fifo_empty[g]==1, clears on fifo_rd; release when it reaches STALL_MAX.
REQ-022 Release: next state IDLE, rr <= (g+1) mod NREQ; delimiter and burst-limit on same word counted as one release.
REQ-023 Latency: FIFO becomes non-empty in IDLE at cycle N -> XFER at N+1 -> first fifo_rd at N+1 if output free -> out_valid at N+2.
REQ-024 Backpressure: out_ready low never loses or duplicates a word; at most one word in output register.
REQ-025 Never asserts fifo_rd on an empty FIFO, nor more than one bit of fifo_rd.
REQ-026 Counters saturate-free: widths ceil(log2(MAX_BURST+1)) and ceil(log2(STALL_MAX+1)).

Reset
REQ-027 While reset high: state IDLE, g=0, rr=0, counters 0, out_valid=0, out_last=0, out_src=0, out_data=0, fifo_rd=0.
REQ-028 Reset mid-message discards the output register contents and partial grant; no fifo_rd during or on first cycle after reset.

Structure
REQ-029 Package req_arb_pkg holds DELIM=8'hee, state enum {IDLE, XFER}, and a clog2 helper.
REQ-030 Sub-module rr_pick: combinational round-robin picker (request vector, rr pointer -> valid, index).

Verification
REQ-031 Single FIFO 0 holds words W0..W2, W2[7:0]=8'hee, out_ready=1 -> out_data W0,W1,W2 on consecutive cycles, out_src=0, out_last only on W2, then IDLE.
REQ-032 FIFOs 0..3 each hold one delimiter word, out_ready=1 -> out_src order 0,1,2,3 with one IDLE cycle between grants.
REQ-033 FIFO 1 holds 12 non-delimiter words, FIFO 2 one word, MAX_BURST=8 -> 8 words from 1, then 1 word from 2, then remaining 4 from 1.
REQ-034 out_ready low 5 cycles mid-message -> out_data stable, fifo_rd zero, no word lost; sequence continues after ready.
REQ-035 FIFO 3 empties mid-message for 16 cycles (STALL_MAX=16) while FIFO 0 non-empty -> grant released, out_src=0 next.
REQ-036 Reset asserted while out_valid=1 mid-message -> out_valid=0 same cycle, rr=0, arbitration restarts from FIFO 0.
